fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC (word address), issues one request at a time to a
// variable-latency instruction memory, buffers returned instructions in a
// DEPTH-entry FIFO and hands them to decode with a valid/stall handshake.
// Redirects flush the FIFO and discard any stale in-flight response.
//
// Ports:
//   clk, RESET            clock, asynchronous active-high reset
//   redirect, redirect_pc taken-branch pulse and its word-address target
//   imem_req, imem_addr   registered fetch request and its word address
//   imem_gnt              memory accepts the request (req & gnt)
//   imem_rvalid/rdata     response strobe and returned instruction
//   if_valid, if_instr,   FIFO head valid, head instruction and PC+1
//   if_pcplus1
//   id_stall              decode not ready; pop = if_valid & !id_stall
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pcplus1,
    input  logic        id_stall
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   req_pc, req_pc_next;
    logic          drop, drop_next;
    logic [CW-1:0] count, count_next, occ_after_pop;
    logic [PW-1:0] rd_ptr, rd_ptr_next;
    logic [PW-1:0] wr_ptr, wr_ptr_next;
    logic          push, pop;
    logic [31:0]   push_pcp1;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pcp1  [DEPTH];

    logic          req_q;
    logic          valid_q;
    logic [31:0]   instr_q, pcp1_q;
    logic [31:0]   head_instr_next, head_pcp1_next;

    // FIFO bookkeeping; a redirect empties the queue and wins over any pop
    always_comb begin
        pop           = valid_q && !id_stall && !redirect;
        push          = (state == ST_WAIT) && imem_rvalid && !drop && !redirect;
        push_pcp1     = req_pc + 32'd1;
        occ_after_pop = count - CW'(pop);
        if (redirect) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            count_next  = occ_after_pop + CW'(push);
            rd_ptr_next = rd_ptr + PW'(pop);
            wr_ptr_next = wr_ptr + PW'(push);
        end
    end

    // Next head entry so the decode-facing outputs come straight from flops;
    // an entry pushed into an otherwise empty queue becomes the head directly
    always_comb begin
        head_instr_next = 32'h0;
        head_pcp1_next  = 32'h0;
        if (count_next != '0) begin
            if (occ_after_pop == '0) begin
                head_instr_next = imem_rdata;
                head_pcp1_next  = push_pcp1;
            end else begin
                head_instr_next = mem_instr[rd_ptr_next];
                head_pcp1_next  = mem_pcp1[rd_ptr_next];
            end
        end
    end

    // Request FSM: at most one outstanding request; a slot is always
    // reserved for it, so the FIFO cannot overflow
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        drop_next     = drop;

        case (state)
            ST_IDLE: begin
                if (redirect || (count_next < DEPTH_C)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd1;
                    // granted address is already stale if redirected now
                    drop_next     = redirect;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    drop_next  = 1'b0;
                    state_next = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
                end else if (redirect) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_next = redirect_pc;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            drop     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            pcp1_q   <= 32'h0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
            drop     <= drop_next;
            count    <= count_next;
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            req_q    <= (state_next == ST_REQ);
            valid_q  <= (count_next != '0);
            instr_q  <= head_instr_next;
            pcp1_q   <= head_pcp1_next;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_instr[i] <= 32'h0;
                mem_pcp1[i]  <= 32'h0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pcp1[wr_ptr]  <= push_pcp1;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc;
    assign if_valid   = valid_q;
    assign if_instr   = instr_q;
    assign if_pcplus1 = pcp1_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit.
// A single-outstanding memory responder feeds the DUT; the reference model
// expects decode to see consecutive word addresses starting at the reset PC
// or the latest redirect target, with each entry carrying mem(pc) and pc+1.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        RESET;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pcplus1;
    logic        id_stall;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pcplus1  (if_pcplus1),
        .id_stall    (id_stall)
    );

    int          n_assert = 0;
    int          n_fail   = 0;

    // reference model / memory responder state
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          gnt_mode;
    int          lat_min, lat_max;
    int          pops;
    bit          grant_seen;
    logic [31:0] grant_addr;
    bit          wrap_seen;
    logic        d_redirect, d_stall;
    logic [31:0] d_target;
    bit          found;
    int          pops_before;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance.
    task automatic cycle();
        logic rv;
        logic granted;
        imem_gnt    = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(gnt_mode);
        rv          = pend && (pend_wait == 0);
        imem_rvalid = rv;
        imem_rdata  = rv ? memf(pend_addr) : 32'h0;
        redirect    = d_redirect;
        redirect_pc = d_target;
        id_stall    = d_stall;

        if (!if_valid) begin
            chk("empty_instr", if_instr, 32'h0);
            chk("empty_pcplus1", if_pcplus1, 32'h0);
        end
        chk("one_outstanding", 32'(imem_req && pend), 32'h0);
        if (if_valid && !id_stall && !redirect) begin
            chk("pop_instr", if_instr, memf(exp_pc));
            chk("pop_pcplus1", if_pcplus1, 32'(exp_pc + 32'd1));
            if (32'(exp_pc + 32'd1) == 32'h0) wrap_seen = 1'b1;
            exp_pc = exp_pc + 32'd1;
            pops++;
        end
        if (redirect) exp_pc = redirect_pc;
        granted = imem_req && imem_gnt;
        if (granted) begin
            grant_seen = 1'b1;
            grant_addr = imem_addr;
        end

        @(posedge clk);
        if (rv) pend = 1'b0;
        else if (pend) pend_wait--;
        if (granted) begin
            pend      = 1'b1;
            pend_addr = grant_addr;
            pend_wait = int'($urandom_range(lat_min, lat_max)) - 1;
        end
        d_redirect = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        RESET       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_stall    = 1'b0;
        d_redirect  = 1'b0;
        d_stall     = 1'b0;
        d_target    = 32'h0;
        gnt_mode    = 0;
        lat_min     = 1;
        lat_max     = 1;
        pend        = 1'b0;
        exp_pc      = RESET_PC;
        grant_seen  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pcplus1", if_pcplus1, 32'h0);
        @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    task automatic run_until_grant(input string tag, input logic [31:0] exp_addr);
        grant_seen = 1'b0;
        for (int i = 0; i < 100 && !grant_seen; i++) cycle();
        chk({tag, "_seen"}, 32'(grant_seen), 32'h1);
        if (grant_seen) chk(tag, grant_addr, exp_addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pcp1);
        for (int i = 0; i < 100 && !if_valid; i++) cycle();
        chk({tag, "_valid"}, 32'(if_valid), 32'h1);
        chk({tag, "_pcplus1"}, if_pcplus1, exp_pcp1);
        chk({tag, "_instr"}, if_instr, memf(32'(exp_pcp1 - 32'd1)));
    endtask

    initial begin
        RESET     = 1'b1;
        wrap_seen = 1'b0;
        pops      = 0;

        // streaming fetch, gnt tied high, one-cycle response
        do_reset();
        gnt_mode = 1;
        run_until_grant("t1_addr0", 32'h0);
        run_until_grant("t1_addr1", 32'h1);
        run_until_grant("t1_addr2", 32'h2);
        pops_before = pops;
        repeat (12) cycle();
        chk("t1_progress", 32'(pops - pops_before >= 3), 32'h1);

        // decode stalled: FIFO fills, requests stop, then drains back-to-back
        do_reset();
        gnt_mode = 1;
        d_stall  = 1'b1;
        repeat (15) cycle();
        chk("t2_full_valid", 32'(if_valid), 32'h1);
        chk("t2_idle_req", 32'(imem_req), 32'h0);
        chk("t2_head_pcplus1", if_pcplus1, 32'h1);
        d_stall    = 1'b0;
        grant_seen = 1'b0;
        cycle();
        chk("t2_second_valid", 32'(if_valid), 32'h1);
        chk("t2_second_pcplus1", if_pcplus1, 32'h2);
        cycle();
        chk("t2_resume_seen", 32'(grant_seen), 32'h1);
        chk("t2_resume_addr", grant_addr, 32'h2);

        // redirect while waiting on a slow response
        do_reset();
        gnt_mode = 1;
        lat_min  = 3;
        lat_max  = 3;
        run_until_grant("t3_first", 32'h0);
        d_redirect = 1'b1;
        d_target   = 32'h40;
        cycle();
        run_until_grant("t3_retarget", 32'h40);
        wait_valid("t3_out", 32'h41);

        // redirect coincident with a response, one entry queued
        do_reset();
        gnt_mode = 1;
        d_stall  = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pend && pend_wait == 0 && if_valid) found = 1'b1;
            else cycle();
        end
        chk("t4_setup", 32'(found), 32'h1);
        d_stall    = 1'b0;
        d_redirect = 1'b1;
        d_target   = 32'h80;
        cycle();
        chk("t4_flushed", 32'(if_valid), 32'h0);
        run_until_grant("t4_retarget", 32'h80);
        wait_valid("t4_out", 32'h81);

        // redirect in REQ without grant, near the top of the address space
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < 10 && !imem_req; i++) cycle();
        chk("t5_req", 32'(imem_req), 32'h1);
        d_redirect = 1'b1;
        d_target   = 32'hFFFF_FFFE;
        cycle();
        chk("t5_addr", imem_addr, 32'hFFFF_FFFE);
        chk("t5_req_held", 32'(imem_req), 32'h1);
        gnt_mode = 1;
        lat_max  = 2;
        run_until_grant("t5_grant", 32'hFFFF_FFFE);
        wait_valid("t5_out", 32'hFFFF_FFFF);
        repeat (20) cycle();
        chk("t5_wrap", 32'(wrap_seen), 32'h1);

        // asynchronous reset while waiting, then a late response
        do_reset();
        gnt_mode = 1;
        lat_min  = 4;
        lat_max  = 4;
        run_until_grant("t6_pre", 32'h0);
        cycle();
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_async_addr", imem_addr, RESET_PC);
        chk("t6_async_req", 32'(imem_req), 32'h0);
        chk("t6_async_valid", 32'(if_valid), 32'h0);
        pend     = 1'b0;
        exp_pc   = RESET_PC;
        gnt_mode = 0;
        @(posedge clk);
        #1;
        pend      = 1'b1;
        pend_addr = 32'h77;
        pend_wait = 0;
        cycle();
        RESET     = 1'b0;
        pend      = 1'b1;
        pend_addr = 32'h78;
        pend_wait = 0;
        cycle();
        gnt_mode = 1;
        lat_min  = 1;
        lat_max  = 1;
        run_until_grant("t6_restart", RESET_PC);
        wait_valid("t6_out", 32'(RESET_PC + 32'd1));

        // randomized grants, latencies, stalls and redirects
        do_reset();
        gnt_mode    = 2;
        lat_min     = 1;
        lat_max     = 4;
        pops_before = pops;
        for (int i = 0; i < 3000; i++) begin
            d_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) begin
                d_redirect = 1'b1;
                d_target   = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                                         : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            end
            cycle();
        end
        chk("t7_progress", 32'(pops - pops_before > 150), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
